uart_tx_buffer: RTL and testbench

Byte FIFO and issue sequencer that sits directly upstream of the UART transmitter in the UART-AXI4 bridge. It accepts response bytes from the bridge core over a valid/ready interface, buffers them, and drives the transmitter's `tx_data`/`tx_start` one byte at a time. It honours the transmitter's busy/done handshake and CTS flow control, and never loses a byte when CTS deasserts around the start pulse.

---
 rtl/uart_tx_buffer.sv | 101 ++++++++++
 tb/tb_uart_tx_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter: buffers bridge response bytes and
// issues them one at a time, retrying any start the transmitter rejects on CTS.
module uart_tx_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             flush,
   input  logic             uart_cts_n,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   output logic [CNT_W-1:0] fifo_count,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             overflow,
   output logic             tx_idle
);
   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] CONFIRM   = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    state;
   logic          pop_kill;
   logic          push, pop, start;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
   assign wr_ready   = !fifo_full;
   assign tx_idle    = fifo_empty && (state == IDLE);

   // A flush seen in ISSUE or CONFIRM lets the handshake finish but must not pop
   // the (already cleared) FIFO.
   assign push  = wr_valid && wr_ready && !flush;
   assign pop   = (state == CONFIRM) && tx_busy && !flush && !pop_kill && !fifo_empty;
   assign start = (state == IDLE) && !fifo_empty && !tx_busy && !uart_cts_n && !flush;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_valid && fifo_full && !flush) overflow <= 1'b1;
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + 1'b1;
               2'b01:   fifo_count <= fifo_count - 1'b1;
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         pop_kill <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         pop_kill <= (state == ISSUE) && flush;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_data  <= mem[rd_ptr];
                  tx_start <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE:     state <= CONFIRM;
            // Busy low here means the transmitter saw CTS high and ignored the start.
            CONFIRM:   state <= tx_busy ? WAIT_DONE : IDLE;
            WAIT_DONE: if (tx_done) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: a small transmitter model accepts starts,
// and a negedge monitor compares every accepted byte against the expected queue.
module tb_uart_tx_buffer;
   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic             flush;
   logic             uart_cts_n;
   logic             tx_busy;
   logic             tx_done;
   logic [7:0]       tx_data;
   logic             tx_start;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_full;
   logic             overflow;
   logic             tx_idle;

   uart_tx_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .flush(flush), .uart_cts_n(uart_cts_n),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_data(tx_data),
      .tx_start(tx_start), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .overflow(overflow), .tx_idle(tx_idle)
   );

   always #5 clk = ~clk;

   int        n_chk  = 0;
   int        n_fail = 0;
   int        n_starts = 0;
   int        n_acc = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Transmitter model: takes a start only when idle with CTS asserted.
   logic [3:0] frm;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         frm     <= '0;
      end else begin
         tx_done <= 1'b0;
         if (tx_busy) begin
            if (frm == 4'd1) begin
               tx_busy <= 1'b0;
               tx_done <= 1'b1;
            end
            frm <= frm - 1'b1;
         end else if (tx_start && !uart_cts_n) begin
            tx_busy <= 1'b1;
            frm     <= 4'd5;
         end
      end
   end

   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_start) begin
            n_starts++;
            chk("start_single_cycle", int'(prev_start), 0);
            if (!uart_cts_n) begin
               n_acc++;
               if (exp_q.size() == 0) chk("unexpected_byte", int'(tx_data), -1);
               else chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
         end
         chk("count_bound", int'(fifo_count <= CNT_W'(DEPTH)), 1);
         prev_start = tx_start;
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input bit expect_tx);
      wr_data  = b;
      wr_valid = 1'b1;
      if (expect_tx) exp_q.push_back(b);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (!(tx_idle && !tx_busy) && k < max) begin
         tick();
         k++;
      end
      chk("idle_within_budget", int'(k < max), 1);
   endtask

   initial begin
      int s0, a0, k;
      rst_n = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; flush = 1'b0; uart_cts_n = 1'b0;
      repeat (2) tick();
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_empty", int'(fifo_empty), 1);
      chk("rst_full", int'(fifo_full), 0);
      chk("rst_wr_ready", int'(wr_ready), 1);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_tx_idle", int'(tx_idle), 1);
      rst_n = 1'b1;
      tick();

      // single byte with exact issue timing
      push(8'hA5, 1);
      chk("t1_count_1", int'(fifo_count), 1);
      chk("t1_no_start_yet", int'(tx_start), 0);
      tick();
      chk("t1_start", int'(tx_start), 1);
      chk("t1_data", int'(tx_data), 8'hA5);
      tick();
      chk("t1_start_drop", int'(tx_start), 0);
      chk("t1_count_held", int'(fifo_count), 1);
      tick();
      chk("t1_count_0", int'(fifo_count), 0);
      wait_idle(100);
      chk("t1_idle", int'(tx_idle), 1);

      // fill to full while CTS blocks, then drain
      uart_cts_n = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i), 1);
      chk("t2_full", int'(fifo_full), 1);
      chk("t2_wr_ready", int'(wr_ready), 0);
      chk("t2_count", int'(fifo_count), 16);
      chk("t2_no_ovf_yet", int'(overflow), 0);
      push(8'h10, 0);
      chk("t2_overflow", int'(overflow), 1);
      chk("t2_count_after_drop", int'(fifo_count), 16);
      uart_cts_n = 1'b0;
      wait_idle(500);
      chk("t2_all_out", exp_q.size(), 0);

      // CTS rejection and retry
      s0 = n_starts; a0 = n_acc;
      push(8'h3C, 1);
      tick();
      chk("t3_start", int'(tx_start), 1);
      uart_cts_n = 1'b1;
      repeat (4) tick();
      chk("t3_not_popped", int'(fifo_count), 1);
      chk("t3_xmit_idle", int'(tx_busy), 0);
      uart_cts_n = 1'b0;
      wait_idle(100);
      chk("t3_two_starts", n_starts - s0, 2);
      chk("t3_one_accept", n_acc - a0, 1);
      chk("t3_sb_empty", exp_q.size(), 0);

      // wrap-around with overlapping push and pop
      for (int i = 0; i < 40; i++) begin
         k = 0;
         while (!wr_ready && k < 200) begin tick(); k++; end
         chk("t4_ready_budget", int'(k < 200), 1);
         push(8'((i * 7) % 256), 1);
      end
      wait_idle(1000);
      chk("t4_sb_empty", exp_q.size(), 0);

      // flush while byte 0 is in flight
      uart_cts_n = 1'b1;
      push(8'h11, 1);
      for (int i = 1; i < 5; i++) push(8'(8'h11 + i), 0);
      uart_cts_n = 1'b0;
      k = 0;
      while (!tx_busy && k < 50) begin tick(); k++; end
      chk("t5_busy_budget", int'(k < 50), 1);
      tick();
      chk("t5_count_4", int'(fifo_count), 4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flushed", int'(fifo_count), 0);
      chk("t5_empty", int'(fifo_empty), 1);
      s0 = n_starts;
      repeat (20) tick();
      chk("t5_no_more_starts", n_starts - s0, 0);
      wait_idle(100);
      chk("t5_sb_empty", exp_q.size(), 0);

      // async reset while tx_start is high
      push(8'h5A, 1);
      k = 0;
      while (!tx_start && k < 20) begin tick(); k++; end
      chk("t6_start_seen", int'(tx_start), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_tx_start", int'(tx_start), 0);
      chk("t6_tx_data", int'(tx_data), 0);
      chk("t6_count", int'(fifo_count), 0);
      chk("t6_empty", int'(fifo_empty), 1);
      chk("t6_full", int'(fifo_full), 0);
      chk("t6_wr_ready", int'(wr_ready), 1);
      chk("t6_overflow", int'(overflow), 0);
      chk("t6_tx_idle", int'(tx_idle), 1);
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t6_quiet_after_reset", int'(tx_start), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
